// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_tx, uart_rx and their benches:
// frame width, default bit timing, FSM state type and parity helper.
package uart_pkg;

    localparam int DATA_BIT          = 8;
    localparam int CLKS_PER_BIT_DEF  = 868;
    localparam int UART_CLOCK_NS     = 10;
    localparam int CLOCK_HALF_PERIOD = UART_CLOCK_NS / 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Parity bit for a word: even parity, inverted for odd parity.
    function automatic logic parity_of(
        input logic [DATA_BIT-1:0] d,
        input logic                odd
    );
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by uart_tx and uart_rx.
// Ports: clk, reset (sync, active-high), clear (hold count at 0),
//        bit_tick (high on the last cycle of each bit period).
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign bit_tick = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BIT data bits LSB first, optional
// parity (macro UART_TX_PARITY_EN), STOP_BITS stop bits.
// Ports: clk, reset (sync, active-high), tx_data/tx_valid/tx_ready
//        word handshake, tx serial line (idles high), tx_busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_BIT-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                tx,
    output logic                tx_busy
);

    localparam int IW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BIT - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    // Illegal parameter sets elaborate this marker block.
    localparam bit CFG_OK = (CLKS_PER_BIT >= 2) &&
                            (STOP_BITS == 1 || STOP_BITS == 2) &&
                            (PARITY_ODD == 0 || PARITY_ODD == 1);
    if (!CFG_OK) begin : g_cfg_error
    end

    uart_state_t         r_state;
    logic [DATA_BIT-1:0] r_shift;
    logic [IW-1:0]       r_idx;
    logic                r_stop_idx;
    logic                r_tx;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif
    logic                w_tick;
    logic                w_idle;

    assign w_idle   = (r_state == IDLE);
    assign tx_ready = w_idle;
    assign tx_busy  = !w_idle;
    assign tx       = r_tx;

    // Counter is held at 0 while idle so START always gets a full period.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_idle),
        .bit_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_valid) begin
                        r_shift    <= tx_data;
                        r_idx      <= '0;
                        r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= parity_of(tx_data, 1'(PARITY_ODD));
`endif
                        r_tx       <= 1'b0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + IW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_stop_idx == STOP_LAST) begin
                            r_state <= IDLE;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected words, a line
// monitor decodes each frame (acting as the receiver) and compares.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam int A5_BITS = 'h54A;
`else
    localparam int NB = 10;
    localparam int A5_BITS = 'h34A;
`endif
    localparam int NS = CPB * NB;

    logic                clk = 1'b0;
    logic                reset;
    logic [DATA_BIT-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                tx;
    logic                tx_busy;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (1),
        .PARITY_ODD   (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    always #CLOCK_HALF_PERIOD clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [DATA_BIT-1:0] exp_q[$];
    int acc_q[$];
    int acc_log[$];
    bit abort_pend = 1'b0;
    bit in_frame = 1'b0;
    int st;
    logic smp [NS];
    bit rdy_ok;
    int last_bits = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance and reset observer
    always @(posedge clk) begin
        if (reset) begin
            abort_pend = 1'b1;
        end else if (tx_valid && tx_ready) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
        end
    end

    task automatic check_frame();
        logic [NB-1:0] bits;
        bit shape_ok;
        logic [DATA_BIT-1:0] d;
        shape_ok = 1'b1;
        for (int b = 0; b < NB; b++) begin
            bits[b] = smp[CPB*b];
            for (int k = 1; k < CPB; k++)
                if (smp[CPB*b+k] !== smp[CPB*b]) shape_ok = 1'b0;
        end
        if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) shape_ok = 1'b0;
        d = bits[DATA_BIT:1];
        last_bits = int'(bits);
        chk("frame_shape", {shape_ok, rdy_ok}, 2'b11);
        if (exp_q.size() == 0) begin
            chk("unexpected_frame", int'(d), -1);
        end else begin
            chk("frame_data", int'(d), int'(exp_q.pop_front()));
        end
        if (acc_q.size() == 0) begin
            chk("no_acceptance", st, -1);
        end else begin
            chk("start_latency", st - acc_q.pop_front(), 1);
        end
`ifdef UART_TX_PARITY_EN
        chk("parity", int'(bits[NB-2]), int'(^d));
`endif
    endtask

    // Line monitor: samples tx every cycle on the falling edge
    always @(negedge clk) begin
        if (abort_pend) begin
            abort_pend = 1'b0;
            if (in_frame) begin
                in_frame = 1'b0;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (acc_q.size() != 0) void'(acc_q.pop_front());
            end
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                st = cyc;
                smp[0] = tx;
                rdy_ok = (tx_ready === 1'b0);
            end
        end else begin
            smp[cyc - st] = tx;
            if (tx_ready !== 1'b0) rdy_ok = 1'b0;
            if (cyc - st == NS - 1) begin
                in_frame = 1'b0;
                check_frame();
            end
        end
    end

    task automatic send(input logic [DATA_BIT-1:0] d);
        @(negedge clk);
        tx_data = d;
        tx_valid = 1'b1;
        exp_q.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || in_frame) && n < 200);
        chk("idle_timeout", n < 200, 1);
    endtask

    task automatic wait_acc(input int target, input int lim);
        int n;
        n = 0;
        while (acc_log.size() < target && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", acc_log.size() >= target, 1);
    endtask

    initial begin
        int a0;
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_tx", tx, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        repeat (20) @(negedge clk);
        chk("idle_tx", tx, 1);
        chk("idle_ready", tx_ready, 1);
        chk("idle_busy", tx_busy, 0);

        // Single frame A5: start, 1,0,1,0,0,1,0,1, [parity 0], stop
        send(8'hA5);
        wait_idle();
        chk("a5_bits", last_bits, A5_BITS);

        // Back-to-back with tx_valid held; data changed mid-frame
        a0 = acc_log.size();
        @(negedge clk);
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        wait_acc(a0 + 1, 10);
        tx_data = 8'h99;
        repeat (20) @(negedge clk);
        tx_data = 8'hC3;
        wait_acc(a0 + 2, 100);
        tx_valid = 1'b0;
        if (acc_log.size() >= a0 + 2)
            chk("b2b_spacing", acc_log[a0+1] - acc_log[a0], NS + 1);
        wait_idle();

        // Reset during data bit 3, with tx_valid high alongside reset
        @(negedge clk);
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        exp_q.push_back(8'hAA);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        reset = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h55;
        @(negedge clk);
        reset = 1'b0;
        tx_valid = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        chk("midrst_q", exp_q.size(), 0);
        send(8'h0F);
        wait_idle();

        // Receiver-side decode of consecutive words
        send(8'h3C);
        wait_idle();
        send(8'hFF);
        wait_idle();

        repeat (10) @(negedge clk);
        chk("final_q", exp_q.size(), 0);
        chk("final_tx", tx, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
